// File: rtl/vic_writeback_buffer.sv
// Writeback buffer behind the victim cache: queues fired lines, drains them
// in order to memory as BUS_STORE requests, and answers same-cycle lookups so
// a dcache miss can forward from a line that has not been written back yet.

package vic_wb_pkg;
   localparam int NUM_SET_BITS = 4;
   localparam int NUM_TAG_BITS = 13;

   typedef struct packed {
      logic                    valid;
      logic [NUM_TAG_BITS-1:0] tag;
      logic [63:0]             data;
   } CACHE_LINE_T;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;
endpackage

// state | meaning
// IDLE  | buffer empty, no request on the bus
// STORE | head entry presented to memory, retried until accepted
module vic_writeback_buffer
   import vic_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       fired_valid,
   input  CACHE_LINE_T                fired_victim,
   input  logic [NUM_SET_BITS-1:0]    fired_set_index,
   input  logic                       lookup_valid,
   input  logic [NUM_TAG_BITS-1:0]    lookup_tag,
   input  logic [NUM_SET_BITS-1:0]    lookup_set_index,
   output logic                       lookup_hit,
   output logic [63:0]                lookup_data,
   input  logic                       mem_grant,
   input  logic [3:0]                 mem2proc_response,
   output logic [1:0]                 proc2mem_command,
   output logic [63:0]                proc2mem_addr,
   output logic [63:0]                proc2mem_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int PAD_BITS = 64 - NUM_TAG_BITS - NUM_SET_BITS - 3;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {IDLE, STORE} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           head_q, head_d;
   logic [PW-1:0]           tail_q, tail_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic [DEPTH-1:0]        valid_q;
   logic [NUM_TAG_BITS-1:0] tag_q  [DEPTH];
   logic [NUM_SET_BITS-1:0] set_q  [DEPTH];
   logic [63:0]             data_q [DEPTH];

   logic accept;
   logic enq;
   logic unused_fired_valid_bit;

   // The fired line's own valid bit carries no meaning here; fired_valid qualifies it.
   assign unused_fired_valid_bit = fired_victim.valid;

   // A full buffer still takes a new line when the head leaves on the same edge.
   assign accept = (state_q == STORE) & mem_grant & (|mem2proc_response);
   assign enq    = fired_valid & ((count_q < DEPTH_C) | accept);

   // Pointer, occupancy and sticky-overflow bookkeeping.
   always_comb begin
      head_d     = accept ? head_q + 1'b1 : head_q;
      tail_d     = enq    ? tail_q + 1'b1 : tail_q;
      count_d    = count_q;
      overflow_d = overflow_q | (fired_valid & ~enq);
      case ({enq, accept})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Next state and bus outputs; address/data only leave the block in STORE.
   always_comb begin
      state_d          = state_q;
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      case (state_q)
         IDLE: begin
            if (count_d != '0) state_d = STORE;
         end
         STORE: begin
            proc2mem_command = mem_grant ? BUS_STORE : BUS_NONE;
            proc2mem_addr    = {{PAD_BITS{1'b0}}, tag_q[head_q], set_q[head_q], 3'b000};
            proc2mem_data    = data_q[head_q];
            if (accept && count_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Forwarding lookup: walk oldest to youngest so the youngest match wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx         = '0;
      lookup_hit  = 1'b0;
      lookup_data = '0;
      if (lookup_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && tag_q[idx] == lookup_tag && set_q[idx] == lookup_set_index) begin
               lookup_hit  = 1'b1;
               lookup_data = data_q[idx];
            end
         end
      end
   end

   // Control registers; valid is set after clear so a full-buffer swap keeps the slot live.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         if (accept) valid_q[head_q] <= 1'b0;
         if (enq)    valid_q[tail_q] <= 1'b1;
      end
   end

   // Line storage; contents are qualified by valid_q so they need no reset.
   always_ff @(posedge clock) begin
      if (enq) begin
         tag_q[tail_q]  <= fired_victim.tag;
         set_q[tail_q]  <= fired_set_index;
         data_q[tail_q] <= fired_victim.data;
      end
   end

   assign count    = count_q;
   assign full     = (count_q == DEPTH_C);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_vic_writeback_buffer.sv
// Self-checking bench for vic_writeback_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_vic_writeback_buffer;
   import vic_wb_pkg::*;

   localparam int DEPTH = 4;

   logic        clock, reset;
   logic        fired_valid;
   CACHE_LINE_T fired_victim;
   logic [3:0]  fired_set_index;
   logic        lookup_valid;
   logic [12:0] lookup_tag;
   logic [3:0]  lookup_set_index;
   logic        lookup_hit;
   logic [63:0] lookup_data;
   logic        mem_grant;
   logic [3:0]  mem2proc_response;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr, proc2mem_data;
   logic [2:0]  count;
   logic        full, overflow;

   int n_chk  = 0;
   int n_pass = 0;

   vic_writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .fired_valid(fired_valid), .fired_victim(fired_victim), .fired_set_index(fired_set_index),
      .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_set_index(lookup_set_index),
      .lookup_hit(lookup_hit), .lookup_data(lookup_data),
      .mem_grant(mem_grant), .mem2proc_response(mem2proc_response),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .count(count), .full(full), .overflow(overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: an ordered list of buffered lines plus the sticky drop flag.
   typedef struct {
      logic [12:0] tag;
      logic [3:0]  set;
      logic [63:0] data;
   } ent_t;

   ent_t q[$];
   bit   m_ovf;

   function automatic logic [63:0] mk_addr(input logic [12:0] t, input logic [3:0] s);
      return {44'd0, t, s, 3'b000};
   endfunction

   function automatic logic [1:0] exp_cmd();
      return (q.size() != 0 && mem_grant) ? 2'd2 : 2'd0;
   endfunction

   function automatic logic [63:0] exp_addr();
      return (q.size() != 0) ? mk_addr(q[0].tag, q[0].set) : 64'd0;
   endfunction

   function automatic logic [63:0] exp_data();
      return (q.size() != 0) ? q[0].data : 64'd0;
   endfunction

   // {hit, data}: the last match in arrival order is the youngest.
   function automatic logic [64:0] exp_lookup();
      logic [64:0] r;
      r = '0;
      if (lookup_valid)
         foreach (q[i])
            if (q[i].tag == lookup_tag && q[i].set == lookup_set_index) r = {1'b1, q[i].data};
      return r;
   endfunction

   task automatic model_update();
      bit   acc;
      int   sz;
      ent_t e;
      acc = (q.size() != 0) && mem_grant && (mem2proc_response != 0);
      sz  = q.size();
      if (reset) begin
         q.delete();
         m_ovf = 0;
      end else begin
         if (acc) void'(q.pop_front());
         if (fired_valid) begin
            e.tag  = fired_victim.tag;
            e.set  = fired_set_index;
            e.data = fired_victim.data;
            if (sz < DEPTH || acc) q.push_back(e);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic quiet();
      fired_valid       = 1'b0;
      fired_victim      = '0;
      fired_set_index   = '0;
      lookup_valid      = 1'b0;
      lookup_tag        = '0;
      lookup_set_index  = '0;
      mem_grant         = 1'b0;
      mem2proc_response = '0;
   endtask

   task automatic fire(input logic [12:0] t, input logic [3:0] s, input logic [63:0] d);
      fired_valid        = 1'b1;
      fired_victim.valid = 1'($urandom_range(0, 1));
      fired_victim.tag   = t;
      fired_victim.data  = d;
      fired_set_index    = s;
   endtask

   task automatic test_reset();
      quiet();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      lookup_valid = 1'b1;
      #1;
      n_chk++; if (proc2mem_command !== 2'd0) $display("FAIL rst_cmd got %0d want 0", proc2mem_command); else n_pass++;
      n_chk++; if (proc2mem_addr !== 64'd0) $display("FAIL rst_addr got %h want 0", proc2mem_addr); else n_pass++;
      n_chk++; if (proc2mem_data !== 64'd0) $display("FAIL rst_data got %h want 0", proc2mem_data); else n_pass++;
      n_chk++; if (lookup_hit !== 1'b0 || lookup_data !== 64'd0) $display("FAIL rst_lookup got %b/%h want 0/0", lookup_hit, lookup_data); else n_pass++;
      n_chk++; if (count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_status got cnt=%0d full=%b ovf=%b want 0/0/0", count, full, overflow); else n_pass++;
      quiet();
   endtask

   task automatic test_single_store();
      quiet();
      mem_grant = 1'b1;
      mem2proc_response = 4'd1;
      fire(13'd5, 4'd2, 64'hA5);
      #1;
      n_chk++; if (proc2mem_command !== 2'd0) $display("FAIL single_idle_cmd got %0d want 0", proc2mem_command); else n_pass++;
      tick();
      fired_valid = 1'b0;
      #1;
      n_chk++; if (proc2mem_command !== 2'd2) $display("FAIL single_cmd got %0d want 2", proc2mem_command); else n_pass++;
      n_chk++; if (proc2mem_addr !== 64'h290) $display("FAIL single_addr got %h want 290", proc2mem_addr); else n_pass++;
      n_chk++; if (proc2mem_data !== 64'hA5) $display("FAIL single_data got %h want a5", proc2mem_data); else n_pass++;
      tick();
      #1;
      n_chk++; if (count !== 3'd0) $display("FAIL single_drain_count got %0d want 0", count); else n_pass++;
      n_chk++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 64'd0) $display("FAIL single_idle_after got cmd=%0d addr=%h want 0/0", proc2mem_command, proc2mem_addr); else n_pass++;
      quiet();
   endtask

   task automatic test_overflow();
      quiet();
      for (int i = 0; i < 4; i++) begin
         fire(13'(20 + i), 4'(i), 64'(1000 + i));
         tick();
      end
      fired_valid = 1'b0;
      #1;
      n_chk++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL ovf_full got full=%b cnt=%0d want 1/4", full, count); else n_pass++;
      n_chk++; if (proc2mem_command !== 2'd0) $display("FAIL ovf_no_store got %0d want 0", proc2mem_command); else n_pass++;
      n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow); else n_pass++;
      fire(13'd99, 4'd9, 64'h5555);
      tick();
      fired_valid = 1'b0;
      #1;
      n_chk++; if (overflow !== 1'b1 || count !== 3'd4) $display("FAIL ovf_drop got ovf=%b cnt=%0d want 1/4", overflow, count); else n_pass++;
      n_chk++; if (proc2mem_addr !== mk_addr(13'd20, 4'd0)) $display("FAIL ovf_head got %h want %h", proc2mem_addr, mk_addr(13'd20, 4'd0)); else n_pass++;
      mem_grant = 1'b1;
      mem2proc_response = 4'd3;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_chk++; if (proc2mem_data !== 64'(1000 + i)) $display("FAIL ovf_drain_order got %0d want %0d", proc2mem_data, 1000 + i); else n_pass++;
         tick();
      end
      quiet();
      #1;
      n_chk++; if (count !== 3'd0 || overflow !== 1'b1) $display("FAIL ovf_sticky got cnt=%0d ovf=%b want 0/1", count, overflow); else n_pass++;
   endtask

   task automatic test_back_to_back();
      quiet();
      fire(13'd3, 4'd1, 64'h33);
      tick();
      mem_grant = 1'b1;
      mem2proc_response = 4'd1;
      fire(13'd9, 4'd6, 64'h99);
      #1;
      n_chk++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== mk_addr(13'd3, 4'd1)) $display("FAIL b2b_first got cmd=%0d addr=%h want 2/%h", proc2mem_command, proc2mem_addr, mk_addr(13'd3, 4'd1)); else n_pass++;
      tick();
      fired_valid = 1'b0;
      mem2proc_response = 4'd0;
      #1;
      n_chk++; if (count !== 3'd1) $display("FAIL b2b_count got %0d want 1", count); else n_pass++;
      n_chk++; if (proc2mem_command !== 2'd2) $display("FAIL b2b_store got %0d want 2", proc2mem_command); else n_pass++;
      n_chk++; if (proc2mem_addr !== mk_addr(13'd9, 4'd6) || proc2mem_data !== 64'h99) $display("FAIL b2b_next got %h/%h want %h/99", proc2mem_addr, proc2mem_data, mk_addr(13'd9, 4'd6)); else n_pass++;
      mem2proc_response = 4'd1;
      tick();
      quiet();
      #1;
      n_chk++; if (count !== 3'd0) $display("FAIL b2b_drain got %0d want 0", count); else n_pass++;
   endtask

   task automatic test_retry();
      quiet();
      fire(13'h1ABC, 4'hF, 64'hDEAD_BEEF_0123_4567);
      tick();
      fired_valid = 1'b0;
      mem_grant = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mem2proc_response = (k == 3) ? 4'h8 : 4'h0;
         #1;
         n_chk++; if (proc2mem_addr !== mk_addr(13'h1ABC, 4'hF) || proc2mem_data !== 64'hDEAD_BEEF_0123_4567) $display("FAIL retry_hold cyc%0d got %h/%h", k, proc2mem_addr, proc2mem_data); else n_pass++;
         n_chk++; if (count !== 3'd1) $display("FAIL retry_count cyc%0d got %0d want 1", k, count); else n_pass++;
         tick();
      end
      quiet();
      #1;
      n_chk++; if (count !== 3'd0 || proc2mem_command !== 2'd0) $display("FAIL retry_done got cnt=%0d cmd=%0d want 0/0", count, proc2mem_command); else n_pass++;
   endtask

   task automatic test_lookup();
      quiet();
      fire(13'd7, 4'd1, 64'd11);
      tick();
      fire(13'd7, 4'd1, 64'd22);
      lookup_valid = 1'b1;
      lookup_tag = 13'd7;
      lookup_set_index = 4'd1;
      #1;
      n_chk++; if (lookup_hit !== 1'b1 || lookup_data !== 64'd11) $display("FAIL lk_same_cycle got %b/%0d want 1/11", lookup_hit, lookup_data); else n_pass++;
      tick();
      fired_valid = 1'b0;
      #1;
      n_chk++; if (lookup_hit !== 1'b1 || lookup_data !== 64'd22) $display("FAIL lk_youngest got %b/%0d want 1/22", lookup_hit, lookup_data); else n_pass++;
      lookup_set_index = 4'd3;
      #1;
      n_chk++; if (lookup_hit !== 1'b0 || lookup_data !== 64'd0) $display("FAIL lk_miss got %b/%0d want 0/0", lookup_hit, lookup_data); else n_pass++;
      lookup_set_index = 4'd1;
      lookup_valid = 1'b0;
      #1;
      n_chk++; if (lookup_hit !== 1'b0 || lookup_data !== 64'd0) $display("FAIL lk_disabled got %b/%0d want 0/0", lookup_hit, lookup_data); else n_pass++;
      lookup_valid = 1'b1;
      mem_grant = 1'b1;
      mem2proc_response = 4'd1;
      tick();
      #1;
      n_chk++; if (lookup_hit !== 1'b1 || lookup_data !== 64'd22 || count !== 3'd1) $display("FAIL lk_dequeue_cycle got %b/%0d cnt=%0d want 1/22/1", lookup_hit, lookup_data, count); else n_pass++;
      tick();
      #1;
      n_chk++; if (lookup_hit !== 1'b0 || count !== 3'd0) $display("FAIL lk_gone got %b cnt=%0d want 0/0", lookup_hit, count); else n_pass++;
      quiet();
   endtask

   task automatic test_reset_mid_store_and_wrap();
      quiet();
      for (int i = 0; i < 3; i++) begin
         fire(13'(40 + i), 4'(i), 64'(500 + i));
         tick();
      end
      fired_valid = 1'b0;
      mem_grant = 1'b1;
      #1;
      n_chk++; if (count !== 3'd3 || proc2mem_command !== 2'd2) $display("FAIL mid_pre got cnt=%0d cmd=%0d want 3/2", count, proc2mem_command); else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_chk++; if (count !== 3'd0 || proc2mem_command !== 2'd0 || overflow !== 1'b0) $display("FAIL mid_reset got cnt=%0d cmd=%0d ovf=%b want 0/0/0", count, proc2mem_command, overflow); else n_pass++;
      mem2proc_response = 4'd2;
      for (int i = 0; i < DEPTH + 2; i++) begin
         fire(13'(i + 1), 4'(i), 64'(100 + i));
         #1;
         if (i > 0) begin
            n_chk++; if (proc2mem_addr !== mk_addr(13'(i), 4'(i - 1)) || proc2mem_data !== 64'(99 + i)) $display("FAIL wrap_head cyc%0d got %h/%0d want %h/%0d", i, proc2mem_addr, proc2mem_data, mk_addr(13'(i), 4'(i - 1)), 99 + i); else n_pass++;
            n_chk++; if (count !== 3'd1) $display("FAIL wrap_count cyc%0d got %0d want 1", i, count); else n_pass++;
         end
         tick();
      end
      fired_valid = 1'b0;
      tick();
      quiet();
      #1;
      n_chk++; if (count !== 3'd0 || proc2mem_command !== 2'd0) $display("FAIL wrap_done got cnt=%0d cmd=%0d want 0/0", count, proc2mem_command); else n_pass++;
   endtask

   task automatic test_random();
      logic [64:0] lk;
      quiet();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 1) == 1)
            fire(13'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), {$urandom, $urandom});
         else
            fired_valid = 1'b0;
         mem_grant = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         mem2proc_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         lookup_valid = 1'($urandom_range(0, 1));
         lookup_tag = 13'($urandom_range(0, 3));
         lookup_set_index = 4'($urandom_range(0, 1));
         #1;
         lk = exp_lookup();
         n_chk++; if (proc2mem_command !== exp_cmd()) $display("FAIL rnd_cmd cyc%0d got %0d want %0d", c, proc2mem_command, exp_cmd()); else n_pass++;
         n_chk++; if (proc2mem_addr !== exp_addr()) $display("FAIL rnd_addr cyc%0d got %h want %h", c, proc2mem_addr, exp_addr()); else n_pass++;
         n_chk++; if (proc2mem_data !== exp_data()) $display("FAIL rnd_data cyc%0d got %h want %h", c, proc2mem_data, exp_data()); else n_pass++;
         n_chk++; if ({lookup_hit, lookup_data} !== lk) $display("FAIL rnd_lookup cyc%0d got %b/%h want %b/%h", c, lookup_hit, lookup_data, lk[64], lk[63:0]); else n_pass++;
         n_chk++; if (count !== 3'(q.size())) $display("FAIL rnd_count cyc%0d got %0d want %0d", c, count, q.size()); else n_pass++;
         n_chk++; if (full !== (q.size() == DEPTH)) $display("FAIL rnd_full cyc%0d got %b want %b", c, full, q.size() == DEPTH); else n_pass++;
         n_chk++; if (overflow !== m_ovf) $display("FAIL rnd_overflow cyc%0d got %b want %b", c, overflow, m_ovf); else n_pass++;
         tick();
      end
      reset = 1'b0;
      quiet();
   endtask

   initial begin
      reset = 1'b1;
      quiet();
      test_reset();
      test_single_store();
      test_overflow();
      test_back_to_back();
      test_retry();
      test_lookup();
      test_reset_mid_store_and_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
